decode_pipe: RTL

Registered instruction-decode stage for the pipelined CPU. It replaces the flat combinational opcode/funct decoder with a single-register pipeline stage that has a valid/ready handshake. The stage decodes a full 32-bit MIPS-subset instruction into a control word, register indices and an extended immediate. It also detects load-use hazards and inserts one bubble, supports flush, and flags illegal encodings. It sits between the fetch buffer and the execute stage.

---
 rtl/decode_pipe_if.sv | 35 +++
 rtl/decode_pipe.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/decode_pipe_if.sv
// Handshake bundle between fetch buffer, decode stage and execute stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_pipe_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [3:0]      out_alu_op;
    logic            out_regwrite, out_memread, out_memwrite, out_branch, out_bne;
    logic            out_jump, out_jump_reg, out_link, out_shift, out_alusrc_imm, out_illegal;
    logic [4:0]      out_rs, out_rt, out_dst, out_shamt;
    logic [31:0]     out_imm;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_op,
        input  out_regwrite, out_memread, out_memwrite, out_branch, out_bne,
        input  out_jump, out_jump_reg, out_link, out_shift, out_alusrc_imm, out_illegal,
        input  out_rs, out_rt, out_dst, out_shamt, out_imm
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_alu_op,
        output out_regwrite, out_memread, out_memwrite, out_branch, out_bne,
        output out_jump, out_jump_reg, out_link, out_shift, out_alusrc_imm, out_illegal,
        output out_rs, out_rt, out_dst, out_shamt, out_imm
    );
endinterface

// File: rtl/decode_pipe.sv
// Registered MIPS-subset decode stage with valid/ready handshake,
// load-use bubble insertion, flush and illegal-encoding detection.
module decode_pipe #(
    parameter int PC_W      = 32,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    decode_pipe_if.slave     bus,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                           ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd8,
                           ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        regwrite, memread, memwrite, branch, bne;
        logic        jump, jump_reg, link, shift, alusrc_imm, illegal;
        logic [4:0]  rs, rt, dst, shamt;
        logic [31:0] imm;
    } ctrl_t;

    ctrl_t           dec, q;
    logic [PC_W-1:0] pc_q;
    logic            valid_q;
    logic            uses_rs, uses_rt, hz, accept;
    logic [5:0]      op, funct;
    logic [15:0]     imm16;

    assign op    = bus.in_inst[31:26];
    assign funct = bus.in_inst[5:0];
    assign imm16 = bus.in_inst[15:0];

    always_comb begin
        dec       = '0;
        dec.rs    = bus.in_inst[25:21];
        dec.rt    = bus.in_inst[20:16];
        dec.shamt = bus.in_inst[10:6];
        uses_rs   = 1'b1;
        uses_rt   = 1'b0;
        case (op)
            6'h00: begin
                uses_rt      = 1'b1;
                dec.dst      = bus.in_inst[15:11];
                dec.regwrite = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec.alu_op = ALU_ADD;
                    6'h22, 6'h23: dec.alu_op = ALU_SUB;
                    6'h24:        dec.alu_op = ALU_AND;
                    6'h25:        dec.alu_op = ALU_OR;
                    6'h26:        dec.alu_op = ALU_XOR;
                    6'h27:        dec.alu_op = ALU_NOR;
                    6'h2A:        dec.alu_op = ALU_SLT;
                    6'h00: begin dec.alu_op = ALU_SLL; dec.shift = 1'b1; uses_rs = 1'b0; end
                    6'h02: begin dec.alu_op = ALU_SRL; dec.shift = 1'b1; uses_rs = 1'b0; end
                    6'h03: begin dec.alu_op = ALU_SRA; dec.shift = 1'b1; uses_rs = 1'b0; end
                    6'h08: begin dec.jump = 1'b1; dec.jump_reg = 1'b1; dec.regwrite = 1'b0; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05: begin
                dec.dst        = bus.in_inst[20:16];
                dec.alusrc_imm = 1'b1;
                dec.regwrite   = 1'b1;
                dec.imm        = {{16{imm16[15]}}, imm16};
                case (op)
                    6'h0A: dec.alu_op = ALU_SLT;
                    6'h0C: begin dec.alu_op = ALU_AND; dec.imm = {16'h0, imm16}; end
                    6'h0D: begin dec.alu_op = ALU_OR;  dec.imm = {16'h0, imm16}; end
                    6'h0E: begin dec.alu_op = ALU_XOR; dec.imm = {16'h0, imm16}; end
                    6'h0F: begin dec.alu_op = ALU_LUI; dec.imm = {imm16, 16'h0}; uses_rs = 1'b0; end
                    6'h23: dec.memread = 1'b1;
                    6'h2B: begin dec.memwrite = 1'b1; dec.regwrite = 1'b0; uses_rt = 1'b1; end
                    6'h04, 6'h05: begin
                        dec.branch   = 1'b1;
                        dec.bne      = op[0];
                        dec.alu_op   = ALU_SUB;
                        dec.regwrite = 1'b0;
                        uses_rt      = 1'b1;
                    end
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            6'h02, 6'h03: begin
                uses_rs  = 1'b0;
                dec.jump = 1'b1;
                dec.imm  = {6'h0, bus.in_inst[25:0]};
                if (op[0]) begin
                    dec.link     = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.dst      = 5'd31;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal word travels down the pipe as a pure marker with no side effects.
        if (dec.illegal) begin
            dec.alu_op     = ALU_ADD;
            dec.regwrite   = 1'b0;
            dec.memread    = 1'b0;
            dec.memwrite   = 1'b0;
            dec.branch     = 1'b0;
            dec.bne        = 1'b0;
            dec.jump       = 1'b0;
            dec.jump_reg   = 1'b0;
            dec.link       = 1'b0;
            dec.shift      = 1'b0;
            dec.alusrc_imm = 1'b0;
            dec.dst        = 5'd0;
            dec.imm        = 32'h0;
        end
        if (dec.dst == 5'd0) dec.regwrite = 1'b0;
    end

    assign hz = HAZARD_EN && valid_q && q.memread && (q.dst != 5'd0) && bus.in_valid &&
                ((uses_rs && dec.rs == q.dst) || (uses_rt && dec.rt == q.dst));

    assign bus.in_ready = !rst && !flush && !hz && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            q         <= '0;
            pc_q      <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                q       <= dec;
                pc_q    <= bus.in_pc;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            // A bubble is only issued when the load actually leaves this cycle.
            if (!flush && hz && bus.out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_alu_op     = q.alu_op;
    assign bus.out_regwrite   = q.regwrite;
    assign bus.out_memread    = q.memread;
    assign bus.out_memwrite   = q.memwrite;
    assign bus.out_branch     = q.branch;
    assign bus.out_bne        = q.bne;
    assign bus.out_jump       = q.jump;
    assign bus.out_jump_reg   = q.jump_reg;
    assign bus.out_link       = q.link;
    assign bus.out_shift      = q.shift;
    assign bus.out_alusrc_imm = q.alusrc_imm;
    assign bus.out_illegal    = q.illegal;
    assign bus.out_rs         = q.rs;
    assign bus.out_rt         = q.rt;
    assign bus.out_dst        = q.dst;
    assign bus.out_shamt      = q.shamt;
    assign bus.out_imm        = q.imm;
endmodule
